// File: rtl/iob_async_fifo_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_async_fifo_rd_ctrl_pkg
// Purpose  : Shared defaults and Gray<->binary helpers for the async FIFO
//            pointer controllers (read side and write side).
// Contents : c_ADDR_W_DEF, c_SYNC_STAGES_DEF - default geometry
//            bin2gray / gray2bin             - width-agnostic conversions
// Revision : 1.0 - initial release
// ============================================================================
package iob_async_fifo_rd_ctrl_pkg;

    localparam int c_ADDR_W_DEF      = 4;
    localparam int c_SYNC_STAGES_DEF = 2;

    // Conversions operate on a wide container. Callers zero-extend their
    // pointer into it and truncate the result; zero upper bits do not disturb
    // either conversion, so one function serves every pointer width.
    localparam int c_CONV_W = 32;
    typedef logic [c_CONV_W-1:0] conv_t;

    function automatic conv_t bin2gray(input conv_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic conv_t gray2bin(input conv_t gray);
        conv_t bin;
        bin[c_CONV_W-1] = gray[c_CONV_W-1];
        for (int i = c_CONV_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_async_fifo_rd_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module   : iob_async_fifo_rd_ctrl_sync
// Purpose  : Multi-flop synchronizer for a Gray-coded pointer crossing into
//            the local clock domain.
// Ports    : clk_i  - local clock
//            cke_i  - clock enable, low holds the chain
//            arst_i - asynchronous active-high reset, loads RST_VAL
//            d_i    - asynchronous input
//            q_o    - synchronized output (last flop of the chain)
// Revision : 1.0 - initial release
// ============================================================================
module iob_async_fifo_rd_ctrl_sync #(
    parameter int                DATA_W  = 5,
    parameter int                STAGES  = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [STAGES-1:0][DATA_W-1:0] r_stage;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_stage <= {STAGES{RST_VAL}};
        end else if (cke_i) begin
            r_stage <= {r_stage[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/iob_async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iob_async_fifo_rd_ctrl
// Purpose  : Read-side pointer controller of the async FIFO. Synchronizes the
//            Gray write pointer, owns the read pointer and produces the empty
//            flag, fill level and RAM read address/enable.
// Ports    : clk_i          - clock
//            cke_i          - clock enable, low freezes every register
//            arst_i         - asynchronous active-high reset
//            wr_ptr_gray_i  - write pointer (Gray), asynchronous to clk_i
//            rd_en_i        - read request
//            rd_ptr_gray_o  - read pointer (Gray), registered, to write side
//            rd_addr_o      - RAM read address
//            mem_en_o       - RAM read enable (accepted read)
//            empty_o        - FIFO empty, registered
//            level_o        - entries available, registered
//            underflow_o    - sticky read-while-empty flag, only when
//                             IOB_ASYNC_FIFO_RD_UNDERFLOW_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module iob_async_fifo_rd_ctrl
    import iob_async_fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W_DEF,
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEF
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic [ADDR_W:0]   wr_ptr_gray_i,
    input  logic              rd_en_i,
    output logic [ADDR_W:0]   rd_ptr_gray_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              mem_en_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
`ifdef IOB_ASYNC_FIFO_RD_UNDERFLOW_EN
    ,
    output logic              underflow_o
`endif
);

    localparam int c_PTR_W = ADDR_W + 1;

    logic [c_PTR_W-1:0] w_wr_gray_sync;
    logic [c_PTR_W-1:0] w_wr_bin;
    logic               w_rd_acc;
    logic [c_PTR_W-1:0] w_rd_bin_next;
    logic [c_PTR_W-1:0] w_rd_gray_next;

    logic [c_PTR_W-1:0] r_rd_bin;
    logic [c_PTR_W-1:0] r_rd_gray;
    logic               r_empty;
    logic [c_PTR_W-1:0] r_level;

    iob_async_fifo_rd_ctrl_sync #(
        .DATA_W  (c_PTR_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ('0)
    ) u_wr_ptr_sync (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .d_i    (wr_ptr_gray_i),
        .q_o    (w_wr_gray_sync)
    );

    assign w_wr_bin       = c_PTR_W'(gray2bin(conv_t'(w_wr_gray_sync)));

    // A read is accepted only on an enabled edge while data is present.
    assign w_rd_acc       = cke_i & rd_en_i & ~r_empty;
    assign w_rd_bin_next  = r_rd_bin + c_PTR_W'(w_rd_acc);
    assign w_rd_gray_next = c_PTR_W'(bin2gray(conv_t'(w_rd_bin_next)));

    // Flags are derived from the post-read pointer so a read shows up on
    // empty_o/level_o at the very edge that accepts it.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_rd_bin  <= '0;
            r_rd_gray <= '0;
            r_empty   <= 1'b1;
            r_level   <= '0;
        end else if (cke_i) begin
            r_rd_bin  <= w_rd_bin_next;
            r_rd_gray <= w_rd_gray_next;
            r_empty   <= (w_wr_gray_sync == w_rd_gray_next);
            r_level   <= w_wr_bin - w_rd_bin_next;
        end
    end

`ifdef IOB_ASYNC_FIFO_RD_UNDERFLOW_EN
    logic r_underflow;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_underflow <= 1'b0;
        end else if (cke_i && rd_en_i && r_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign underflow_o = r_underflow;
`endif

    assign rd_ptr_gray_o = r_rd_gray;
    assign rd_addr_o     = r_rd_bin[ADDR_W-1:0];
    assign mem_en_o      = w_rd_acc;
    assign empty_o       = r_empty;
    assign level_o       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_iob_async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_async_fifo_rd_ctrl
// Purpose  : Self-checking bench for iob_async_fifo_rd_ctrl (ADDR_W=4,
//            SYNC_STAGES=2). Reference model tracks pointers as integer
//            counts and models the crossing as a pure delay of the sampled
//            write count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_async_fifo_rd_ctrl;

    localparam int c_AW    = 4;
    localparam int c_SS    = 2;
    localparam int c_DEPTH = 16;
    localparam int c_MODN  = 32;

    logic            clk = 1'b0;
    logic            cke_i;
    logic            arst_i;
    logic [c_AW:0]   wr_ptr_gray_i;
    logic            rd_en_i;
    logic [c_AW:0]   rd_ptr_gray_o;
    logic [c_AW-1:0] rd_addr_o;
    logic            mem_en_o;
    logic            empty_o;
    logic [c_AW:0]   level_o;
`ifdef IOB_ASYNC_FIFO_RD_UNDERFLOW_EN
    logic            underflow_o;
`endif

    iob_async_fifo_rd_ctrl #(
        .ADDR_W      (c_AW),
        .SYNC_STAGES (c_SS)
    ) dut (
        .clk_i         (clk),
        .cke_i         (cke_i),
        .arst_i        (arst_i),
        .wr_ptr_gray_i (wr_ptr_gray_i),
        .rd_en_i       (rd_en_i),
        .rd_ptr_gray_o (rd_ptr_gray_o),
        .rd_addr_o     (rd_addr_o),
        .mem_en_o      (mem_en_o),
        .empty_o       (empty_o),
        .level_o       (level_o)
`ifdef IOB_ASYNC_FIFO_RD_UNDERFLOW_EN
        ,
        .underflow_o   (underflow_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int       m_rd;       // read count mod 32
    int       m_level;
    bit       m_empty;
    bit       m_uf;
    int       wr_cnt;     // write count mod 32 as driven by the bench
    int       hist[$];    // write count sampled at each enabled edge
    int       n_men;
    int       wraps;
    logic [c_AW:0] prev_gray;

    function automatic logic [c_AW:0] to_gray(input int v);
        logic [c_AW:0] b;
        b = (c_AW+1)'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit ck, input bit rd);
        cke_i         = ck;
        rd_en_i       = rd;
        wr_ptr_gray_i = to_gray(wr_cnt);
        #1;
    endtask

    task automatic do_reset();
        arst_i        = 1'b1;
        rd_en_i       = 1'b0;
        wr_cnt        = 0;
        wr_ptr_gray_i = '0;
        #1;
        check("rst_gray",  32'(rd_ptr_gray_o), 0);
        check("rst_addr",  32'(rd_addr_o),     0);
        check("rst_empty", 32'(empty_o),       1);
        check("rst_level", 32'(level_o),       0);
`ifdef IOB_ASYNC_FIFO_RD_UNDERFLOW_EN
        check("rst_uf",    32'(underflow_o),   0);
`endif
        hist.delete();
        m_rd      = 0;
        m_level   = 0;
        m_empty   = 1'b1;
        m_uf      = 1'b0;
        prev_gray = '0;
        arst_i    = 1'b0;
        #1;
    endtask

    // One clock cycle: check combinational outputs, take the edge, advance
    // the model, check registered outputs.
    task automatic tick();
        bit exp_men;
        int seen;
        exp_men = cke_i && rd_en_i && !m_empty;
        check("mem_en",      32'(mem_en_o),  32'(exp_men));
        check("rd_addr_pre", 32'(rd_addr_o), 32'(m_rd % c_DEPTH));
        if (mem_en_o) n_men++;
        @(posedge clk);
        if (cke_i) begin
            if (rd_en_i && m_empty) m_uf = 1'b1;
            hist.push_back(wr_cnt);
            seen    = (hist.size() > c_SS) ? hist[hist.size()-c_SS-1] : 0;
            if (exp_men) m_rd = (m_rd + 1) % c_MODN;
            m_empty = (seen == m_rd);
            m_level = (seen - m_rd + c_MODN) % c_MODN;
        end
        #1;
        check("gray",  32'(rd_ptr_gray_o), 32'(to_gray(m_rd)));
        check("addr",  32'(rd_addr_o),     32'(m_rd % c_DEPTH));
        check("empty", 32'(empty_o),       32'(m_empty));
        check("level", 32'(level_o),       32'(m_level));
        check("gray_step", 32'($countones(rd_ptr_gray_o ^ prev_gray) <= 1), 1);
`ifdef IOB_ASYNC_FIFO_RD_UNDERFLOW_EN
        check("underflow", 32'(underflow_o), 32'(m_uf));
`endif
        if (prev_gray == 5'b10000 && rd_ptr_gray_o == 5'b00000) wraps++;
        prev_gray = rd_ptr_gray_o;
    endtask

    initial begin
        cke_i   = 1'b1;
        rd_en_i = 1'b0;
        n_men   = 0;
        wraps   = 0;
        do_reset();

        // Write visibility latency: 0 -> 1 appears after exactly 3 edges.
        wr_cnt = 1;
        drive(1, 0); tick();
        drive(1, 0); tick();
        check("lat_empty_e2", 32'(empty_o), 1);
        drive(1, 0); tick();
        check("lat_empty_e3", 32'(empty_o), 0);
        check("lat_level_e3", 32'(level_o), 1);

        // Drain three entries with the request held for five cycles.
        wr_cnt = 2; drive(1, 0); tick();
        wr_cnt = 3; drive(1, 0); tick();
        for (int i = 0; i < 3; i++) begin drive(1, 0); tick(); end
        check("drain_lvl3", 32'(level_o), 3);
        n_men = 0;
        for (int i = 0; i < 5; i++) begin drive(1, 1); tick(); end
        check("drain_pulses", 32'(n_men), 3);
        check("drain_empty", 32'(empty_o), 1);
        check("drain_ptr", 32'(rd_ptr_gray_o), 32'(5'b00010));

        // Full: write pointer 16 ahead of read pointer 0.
        do_reset();
        for (int i = 1; i <= 16; i++) begin wr_cnt = i; drive(1, 0); tick(); end
        for (int i = 0; i < 3; i++) begin drive(1, 0); tick(); end
        check("full_level", 32'(level_o), 16);
        check("full_empty", 32'(empty_o), 0);
        for (int i = 0; i < 18; i++) begin drive(1, 1); tick(); end
        check("p16_empty", 32'(empty_o), 1);
        check("p16_gray",  32'(rd_ptr_gray_o), 32'(5'b11000));
        check("p16_level", 32'(level_o), 0);

`ifdef IOB_ASYNC_FIFO_RD_UNDERFLOW_EN
        // Sticky underflow: set by a read while empty, held until reset.
        do_reset();
        drive(1, 1); tick();
        check("uf_set", 32'(underflow_o), 1);
        for (int i = 0; i < 3; i++) begin drive(1, 0); tick(); end
        check("uf_hold", 32'(underflow_o), 1);
        do_reset();
`endif

        // Randomized traffic with clock-enable gaps and rare mid-stream resets.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                bit ck;
                bit rd;
                ck = ($urandom_range(0, 9) != 0);
                rd = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 1) == 1 &&
                    ((wr_cnt - m_rd + c_MODN) % c_MODN) < c_DEPTH)
                    wr_cnt = (wr_cnt + 1) % c_MODN;
                drive(ck, rd);
                tick();
            end
        end
        check("wrap_seen", 32'(wraps > 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
